supernova_vmem_responder: RTL and testbench
===========================================

# supernova_vmem_responder

Responder end of the SuperNova VPU vector memory interface: accepts one VLEN-wide load or store from the VPU's `vmem_*` initiator port and services it as a sequence of BEAT-wide transfers on the narrower L1 data bus. Load beats are assembled into a full vector before acknowledging; store vectors are sliced into beats. Sits between the VPU and the L1 D-cache/scratchpad port. Also keeps transaction counters for the performance-counter block.

## Interface
- `VLEN`, 256: vector width in bits; must be a multiple of `BEAT`.
- `XLEN`, 64: address width.
- `BEAT`, 64: backing-bus data width; power of two, at least 8.

- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `vmem_req`  in  1  VPU request; `vmem_we`/`vmem_addr`/`vmem_wdata` are valid while it is high.
- `vmem_we`  in  1  1 = store, 0 = load.
- `vmem_addr`  in  XLEN  byte address of the vector.
- `vmem_wdata`  in  VLEN  store data.
- `vmem_rdata`  out  VLEN  load data; valid with `vmem_ack`, held until the next load completes.
- `vmem_ack`  out  1  one-cycle completion pulse.
- `mem_req`  out  1  beat request; held until accepted.
- `mem_we`  out  1  beat direction.
- `mem_addr`  out  XLEN  beat byte address, `BEAT/8`-aligned.
- `mem_wdata`  out  BEAT  store beat data.
- `mem_rdata`  in  BEAT  load beat data; valid when `mem_req && mem_ack`.
- `mem_ack`  in  1  beat accept; may be high in the same cycle `mem_req` rises.
- `txn_cnt`  out  64  completed vector transactions.
- `misalign_cnt`  out  64  transactions whose address was not `BEAT/8`-aligned.

## Operation
- `NBEATS = VLEN/BEAT` and `BB = BEAT/8`.
- FSM states:
  - IDLE: if `vmem_req`, capture `we`, `wdata`, base = `vmem_addr` with the low `log2(BB)` bits cleared, and beat index = 0.
    - If any cleared bit was nonzero, increment `misalign_cnt`; the transaction is still serviced at the aligned address.
    - Go to BEAT.
  - BEAT: `mem_req=1`, `mem_we=we`, `mem_addr = base + idx*BB`, `mem_wdata = wdata[idx*BEAT +: BEAT]`.
    - On `mem_ack`: for a load, write `mem_rdata` into the assembly buffer slice `idx`.
    - If `idx == NBEATS-1`, go to RESP; otherwise increment `idx`.
  - RESP: `vmem_ack=1`. For a load, `vmem_rdata` is updated from the assembly buffer in this cycle. Increment `txn_cnt`, then go to IDLE.
- Beat address arithmetic is modulo 2^XLEN; wrap past all-ones is silent.
- Stores never modify `vmem_rdata`.
- `vmem_req` is ignored outside IDLE. Inputs are captured once, so the initiator may change them after the capture edge.
- If `vmem_req` is still high in the IDLE cycle after RESP, it starts a new transaction. The initiator must drop `vmem_req` on seeing `vmem_ack` unless it intends a back-to-back request.
- Counters wrap at 2^64.

## Timing
- Reset values (asynchronous, applied immediately): state=IDLE, `vmem_ack=0`, `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `vmem_rdata=0`, `txn_cnt=0`, `misalign_cnt=0`.
- Reset during BEAT drops `mem_req` in the same cycle and abandons the transaction with no ack. Partial store beats already accepted are not undone.
- Zero-wait memory:
  - `vmem_req` is sampled at edge E.
  - `mem_req` is high for cycles E+1 … E+NBEATS.
  - `vmem_ack` is high in cycle E+NBEATS+1.
  - Latency is NBEATS+1 cycles (5 for defaults).
- Each cycle of `mem_ack=0` stalls by one cycle; `mem_req` and all `mem_*` outputs stay stable while stalled.
- Maximum throughput is one transaction per NBEATS+2 cycles.

## Structure
- Shared package `supernova_vmem_pkg`:
  - state enum `vmem_state_e` {IDLE, BEAT, RESP};
  - localparam functions for `NBEATS` and `BB`;
  - beat index width `$clog2(NBEATS)`.
- Sub-module `supernova_vmem_beat_buf`: NBEATS×BEAT register file with an indexed write port and a full-width read port. It serves as the load assembly buffer.
- Elaboration-time assertion that `VLEN % BEAT == 0` and that `BEAT` is a power of two.

## Test plan
- Load, addr 0x1000, zero-wait memory returning beat k = 0x1111_1111_1111_1111×(k+1) -> `mem_addr` 0x1000/0x1008/0x1010/0x1018; ack at E+5; `vmem_rdata` = {0x4444…, 0x3333…, 0x2222…, 0x1111…}; `txn_cnt=1`.
- Store, addr 0x2000, wdata = 256'h0123…(four distinct words), `mem_ack` low 2 cycles on beat 1 -> beats issued in order with correct slices; `mem_*` stable during stall; ack at E+7; `vmem_rdata` unchanged.
- Misaligned load at addr 0x3005 -> beats at 0x3000…0x3018; `misalign_cnt=1`; ack still produced.
- Wrap-around: load at 0xFFFF_FFFF_FFFF_FFF0 -> beat addresses …FFF0, …FFF8, 0x0, 0x8.
- Back-to-back: `vmem_req` held high across ack -> second transaction captured in the IDLE cycle after RESP; acks separated by 6 cycles; `txn_cnt=2`.
- Reset asserted during beat 2 -> `mem_req` low in the same cycle, no ack, counters 0; a new load after reset release completes normally.

Source files
------------

// File: rtl/supernova_vmem_pkg.sv
// rtl/supernova_vmem_pkg.sv - shared types and sizing helpers for the vector memory responder
package supernova_vmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT,
    S_RESP
  } vmem_state_e;

  function automatic int calc_nbeats(input int vlen, input int beat);
    return vlen / beat;
  endfunction

  function automatic int calc_bb(input int beat);
    return beat / 8;
  endfunction

  // A single-beat vector still needs a one-bit index register.
  function automatic int calc_idx_w(input int nbeats);
    return (nbeats > 1) ? $clog2(nbeats) : 1;
  endfunction

endpackage

// File: rtl/supernova_vmem_beat_buf.sv
// rtl/supernova_vmem_beat_buf.sv - beat-indexed assembly buffer with full-width read
module supernova_vmem_beat_buf
  import supernova_vmem_pkg::*;
#(
  parameter int NBEATS = 4,
  parameter int BEAT   = 64,
  parameter int IW     = calc_idx_w(NBEATS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [IW-1:0]            widx,
  input  logic [BEAT-1:0]          wdata,
  output logic [NBEATS*BEAT-1:0]   rdata
);

  logic [NBEATS-1:0][BEAT-1:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem;

endmodule

// File: rtl/supernova_vmem_responder.sv
// rtl/supernova_vmem_responder.sv - services VLEN-wide VPU loads/stores as BEAT-wide L1 transfers
module supernova_vmem_responder
  import supernova_vmem_pkg::*;
#(
  parameter int VLEN = 256,
  parameter int XLEN = 64,
  parameter int BEAT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vmem_req,
  input  logic            vmem_we,
  input  logic [XLEN-1:0] vmem_addr,
  input  logic [VLEN-1:0] vmem_wdata,
  output logic [VLEN-1:0] vmem_rdata,
  output logic            vmem_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [BEAT-1:0] mem_wdata,
  input  logic [BEAT-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic [63:0]     txn_cnt,
  output logic [63:0]     misalign_cnt
);

  localparam int NBEATS = calc_nbeats(VLEN, BEAT);
  localparam int BB     = calc_bb(BEAT);
  localparam int LOG_BB = $clog2(BB);
  localparam int IW     = calc_idx_w(NBEATS);
  localparam logic [XLEN-1:0] OFS_MASK = XLEN'(BB - 1);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NBEATS - 1);

  if ((VLEN % BEAT) != 0 || BEAT < 8 || (BEAT & (BEAT - 1)) != 0) begin : g_bad_params
    $error("supernova_vmem_responder: VLEN must be a multiple of BEAT and BEAT a power of two >= 8");
  end

  vmem_state_e state, state_nxt;

  logic            we_q;
  logic [XLEN-1:0] base_q;
  logic [VLEN-1:0] wdata_q;
  logic [IW-1:0]   idx_q;
  logic [VLEN-1:0] rdata_q;
  logic [VLEN-1:0] buf_rdata;
  logic            buf_we;
  logic            capture;
  logic            beat_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    vmem_ack  = 1'b0;
    buf_we    = 1'b0;
    capture   = 1'b0;
    beat_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (vmem_req) begin
          capture   = 1'b1;
          state_nxt = S_BEAT;
        end
      end
      S_BEAT: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = base_q + (XLEN'(idx_q) << LOG_BB);
        mem_wdata = wdata_q[BEAT*int'(idx_q) +: BEAT];
        if (mem_ack) begin
          buf_we    = ~we_q;
          beat_done = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_nxt = S_RESP;
          end
        end
      end
      S_RESP: begin
        vmem_ack  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q         <= 1'b0;
      base_q       <= '0;
      wdata_q      <= '0;
      idx_q        <= '0;
      rdata_q      <= '0;
      txn_cnt      <= '0;
      misalign_cnt <= '0;
    end else begin
      if (capture) begin
        we_q    <= vmem_we;
        base_q  <= vmem_addr & ~OFS_MASK;
        wdata_q <= vmem_wdata;
        idx_q   <= '0;
        if ((vmem_addr & OFS_MASK) != '0) begin
          misalign_cnt <= misalign_cnt + 64'd1;
        end
      end
      if (beat_done && idx_q != LAST_IDX) begin
        idx_q <= idx_q + IW'(1);
      end
      if (vmem_ack) begin
        txn_cnt <= txn_cnt + 64'd1;
        if (!we_q) begin
          rdata_q <= buf_rdata;
        end
      end
    end
  end

  // Bypass the buffer during RESP so load data is visible alongside the ack.
  assign vmem_rdata = (state == S_RESP && !we_q) ? buf_rdata : rdata_q;

  supernova_vmem_beat_buf #(
    .NBEATS (NBEATS),
    .BEAT   (BEAT),
    .IW     (IW)
  ) u_beat_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (buf_we),
    .widx  (idx_q),
    .wdata (mem_rdata),
    .rdata (buf_rdata)
  );

endmodule

// File: tb/tb_supernova_vmem_responder.sv
// tb/tb_supernova_vmem_responder.sv - directed self-checking bench for supernova_vmem_responder
module tb_supernova_vmem_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         vmem_req;
  logic         vmem_we;
  logic [63:0]  vmem_addr;
  logic [255:0] vmem_wdata;
  logic [255:0] vmem_rdata;
  logic         vmem_ack;
  logic         mem_req;
  logic         mem_we;
  logic [63:0]  mem_addr;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_ack;
  logic [63:0]  txn_cnt;
  logic [63:0]  misalign_cnt;

  logic [63:0]  rd_base;
  int           n_cmp = 0;
  int           n_err = 0;

  logic [63:0]  q_addr[$];
  logic [63:0]  q_wdata[$];
  int           q_we_ones;
  int           lat1;
  int           lat2;
  logic [255:0] ack_rdata;

  localparam logic [255:0] LOAD_PAT = {64'h4444444444444444, 64'h3333333333333333,
                                       64'h2222222222222222, 64'h1111111111111111};
  localparam logic [255:0] ST_DATA  = {64'h8796a5b4c3d2e1f0, 64'h0f1e2d3c4b5a6978,
                                       64'hfedcba9876543210, 64'h0123456789abcdef};

  always #5 clk = ~clk;

  // Beat k of a load (relative to rd_base) returns 0x1111...*(k+1).
  always_comb mem_rdata = 64'h1111111111111111 * (((mem_addr - rd_base) >> 3) + 64'd1);

  supernova_vmem_responder dut (
    .clk          (clk),
    .rst          (rst),
    .vmem_req     (vmem_req),
    .vmem_we      (vmem_we),
    .vmem_addr    (vmem_addr),
    .vmem_wdata   (vmem_wdata),
    .vmem_rdata   (vmem_rdata),
    .vmem_ack     (vmem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .txn_cnt      (txn_cnt),
    .misalign_cnt (misalign_cnt)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues one request; hold_req keeps vmem_req high across the first ack for a back-to-back pair.
  task automatic run_txn(input logic we, input logic [63:0] addr, input logic [255:0] wd,
                         input int stall_beat, input int stall_n, input bit hold_req);
    int nacc;
    int stalled;
    int acks;
    q_addr.delete();
    q_wdata.delete();
    q_we_ones = 0;
    lat1 = -1;
    lat2 = -1;
    nacc = 0;
    stalled = 0;
    acks = 0;
    @(negedge clk);
    vmem_req = 1'b1;
    vmem_we = we;
    vmem_addr = addr;
    vmem_wdata = wd;
    @(posedge clk);
    #1;
    if (!hold_req) begin
      vmem_req = 1'b0;
      vmem_we = ~we;
      vmem_addr = 64'hdeadbeefdeadbeef;
      vmem_wdata = '1;
    end
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (hold_req && acks == 1 && cyc == lat1 + 2) vmem_req = 1'b0;
      if (nacc == stall_beat && stalled < stall_n) begin
        mem_ack = 1'b0;
        stalled++;
      end else begin
        mem_ack = 1'b1;
      end
      #1;
      if (mem_req) begin
        q_addr.push_back(mem_addr);
        q_wdata.push_back(mem_wdata);
        if (mem_we) q_we_ones++;
        if (mem_ack) nacc++;
      end
      if (vmem_ack) begin
        acks++;
        if (acks == 1) begin
          lat1 = cyc;
          ack_rdata = vmem_rdata;
        end else begin
          lat2 = cyc;
        end
        if (acks == (hold_req ? 2 : 1)) break;
      end
    end
    mem_ack = 1'b1;
    check("txn_completed_in_budget", 256'(acks), 256'(hold_req ? 2 : 1));
  endtask

  initial begin
    rst = 1'b1;
    vmem_req = 1'b0;
    vmem_we = 1'b0;
    vmem_addr = '0;
    vmem_wdata = '0;
    mem_ack = 1'b1;
    rd_base = 64'h1000;
    #12;
    check("rst_mem_req", 256'(mem_req), 256'(0));
    check("rst_vmem_ack", 256'(vmem_ack), 256'(0));
    check("rst_mem_addr", 256'(mem_addr), 256'(0));
    check("rst_mem_wdata", 256'(mem_wdata), 256'(0));
    check("rst_mem_we", 256'(mem_we), 256'(0));
    check("rst_vmem_rdata", vmem_rdata, 256'(0));
    check("rst_txn_cnt", 256'(txn_cnt), 256'(0));
    check("rst_misalign_cnt", 256'(misalign_cnt), 256'(0));
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait aligned load
    rd_base = 64'h1000;
    run_txn(1'b0, 64'h1000, '0, -1, 0, 1'b0);
    check("ld_latency", 256'(lat1), 256'(5));
    check("ld_nbeats", 256'(q_addr.size()), 256'(4));
    for (int k = 0; k < 4 && k < q_addr.size(); k++)
      check($sformatf("ld_addr%0d", k), 256'(q_addr[k]), 256'(64'h1000 + 64'(k) * 8));
    check("ld_mem_we", 256'(q_we_ones), 256'(0));
    check("ld_rdata_at_ack", ack_rdata, LOAD_PAT);
    @(negedge clk);
    check("ld_rdata_held", vmem_rdata, LOAD_PAT);
    check("ld_txn_cnt", 256'(txn_cnt), 256'(1));
    check("ld_misalign_cnt", 256'(misalign_cnt), 256'(0));

    // Store with a two-cycle stall on beat 1
    run_txn(1'b1, 64'h2000, ST_DATA, 1, 2, 1'b0);
    check("st_latency", 256'(lat1), 256'(7));
    check("st_cycles", 256'(q_addr.size()), 256'(6));
    if (q_addr.size() == 6) begin
      check("st_addr0", 256'(q_addr[0]), 256'(64'h2000));
      check("st_addr1_stall_a", 256'(q_addr[1]), 256'(64'h2008));
      check("st_addr1_stall_b", 256'(q_addr[2]), 256'(64'h2008));
      check("st_addr1", 256'(q_addr[3]), 256'(64'h2008));
      check("st_addr3", 256'(q_addr[5]), 256'(64'h2018));
      check("st_wdata0", 256'(q_wdata[0]), 256'(64'h0123456789abcdef));
      check("st_wdata1_stall", 256'(q_wdata[1]), 256'(64'hfedcba9876543210));
      check("st_wdata1", 256'(q_wdata[3]), 256'(64'hfedcba9876543210));
      check("st_wdata2", 256'(q_wdata[4]), 256'(64'h0f1e2d3c4b5a6978));
      check("st_wdata3", 256'(q_wdata[5]), 256'(64'h8796a5b4c3d2e1f0));
    end
    check("st_mem_we", 256'(q_we_ones), 256'(6));
    check("st_rdata_at_ack", ack_rdata, LOAD_PAT);
    @(negedge clk);
    check("st_rdata_unchanged", vmem_rdata, LOAD_PAT);
    check("st_txn_cnt", 256'(txn_cnt), 256'(2));

    // Misaligned load is serviced at the aligned base
    rd_base = 64'h3000;
    run_txn(1'b0, 64'h3005, '0, -1, 0, 1'b0);
    check("mis_latency", 256'(lat1), 256'(5));
    if (q_addr.size() == 4) begin
      check("mis_addr0", 256'(q_addr[0]), 256'(64'h3000));
      check("mis_addr3", 256'(q_addr[3]), 256'(64'h3018));
    end
    check("mis_rdata", ack_rdata, LOAD_PAT);
    @(negedge clk);
    check("mis_misalign_cnt", 256'(misalign_cnt), 256'(1));

    // Address wrap past all-ones
    rd_base = 64'hfffffffffffffff0;
    run_txn(1'b0, 64'hfffffffffffffff0, '0, -1, 0, 1'b0);
    if (q_addr.size() == 4) begin
      check("wrap_addr0", 256'(q_addr[0]), 256'(64'hfffffffffffffff0));
      check("wrap_addr1", 256'(q_addr[1]), 256'(64'hfffffffffffffff8));
      check("wrap_addr2", 256'(q_addr[2]), 256'(64'h0));
      check("wrap_addr3", 256'(q_addr[3]), 256'(64'h8));
    end
    check("wrap_rdata", ack_rdata, LOAD_PAT);

    // Back-to-back pair with vmem_req held across the first ack
    rd_base = 64'h4000;
    run_txn(1'b0, 64'h4000, '0, -1, 0, 1'b1);
    check("b2b_first_latency", 256'(lat1), 256'(5));
    check("b2b_ack_spacing", 256'(lat2 - lat1), 256'(6));
    check("b2b_beats", 256'(q_addr.size()), 256'(8));
    @(negedge clk);
    check("b2b_txn_cnt", 256'(txn_cnt), 256'(6));

    // Reset in the middle of beat 2
    rd_base = 64'h5000;
    @(negedge clk);
    vmem_req = 1'b1;
    vmem_we = 1'b0;
    vmem_addr = 64'h5000;
    @(posedge clk);
    #1;
    vmem_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_beat2_req", 256'(mem_req), 256'(1));
    check("rstmid_beat2_addr", 256'(mem_addr), 256'(64'h5010));
    rst = 1'b1;
    #1;
    check("rstmid_mem_req", 256'(mem_req), 256'(0));
    check("rstmid_txn_cnt", 256'(txn_cnt), 256'(0));
    check("rstmid_misalign_cnt", 256'(misalign_cnt), 256'(0));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rstmid_no_ack", 256'(vmem_ack), 256'(0));
    end
    rst = 1'b0;
    rd_base = 64'h6000;
    run_txn(1'b0, 64'h6000, '0, -1, 0, 1'b0);
    check("post_rst_latency", 256'(lat1), 256'(5));
    check("post_rst_rdata", ack_rdata, LOAD_PAT);
    @(negedge clk);
    check("post_rst_txn_cnt", 256'(txn_cnt), 256'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
